// File: rtl/onchip_mem_checker_if.sv
// Avalon-MM link between the memory checker (master) and the on-chip RAM
// slave port s1. Read data comes back a fixed number of cycles after the
// address, so there is no waitrequest or readdatavalid on this bus.
interface onchip_mem_checker_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_chipselect;
  logic                avm_write;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_writedata;
  logic                avm_clken;
  logic [DATA_W-1:0]   avm_readdata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write,
    output avm_byteenable,
    output avm_writedata,
    output avm_clken,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write,
    input  avm_byteenable,
    input  avm_writedata,
    input  avm_clken,
    output avm_readdata
  );
endinterface

// File: rtl/onchip_mem_checker.sv
// On-chip RAM self-test / preload engine. On start it writes a window of
// words with an incrementing pattern derived from the seed, reads the same
// window back and compares each word against the pattern. It reports a
// saturating mismatch count, the first failing address and pass/fail.
// Bus outputs are registered; a READ_LATENCY-deep shift of
// {valid, addr, expected} runs behind the registered read strobe so its
// last stage lines up with avm_readdata.
module onchip_mem_checker #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int ERR_W        = 11
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base,
  input  logic [ADDR_W:0]      length,
  input  logic [DATA_W-1:0]    seed,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  onchip_mem_checker_if.master avm
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t state;
  state_t state_next;

  // Run parameters captured at start so the inputs may change mid-run
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  length_q;
  logic [DATA_W-1:0] seed_q;

  // Registered bus drive plus the expected word of the read on the bus
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_exp_q;
  logic              cs_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;

  // Words still to issue in the current phase after the one on the bus
  logic [CNT_W-1:0]  remain_q;

  // Compare pipeline, stage READ_LATENCY-1 is aligned with avm_readdata
  logic              pipe_valid [READ_LATENCY];
  logic [ADDR_W-1:0] pipe_addr  [READ_LATENCY];
  logic [DATA_W-1:0] pipe_exp   [READ_LATENCY];

  logic              start_accept;
  logic              last_word;
  logic              front_busy;
  logic              mismatch;
  logic [ERR_W-1:0]  err_after;

  assign start_accept = (state == S_IDLE) && start;
  assign last_word    = (remain_q == '0);

  // A read is still in flight if it is on the bus or in any stage before the compare stage
  always_comb begin
    front_busy = cs_q & ~we_q;
    for (int k = 0; k < READ_LATENCY - 1; k++) begin
      front_busy = front_busy | pipe_valid[k];
    end
  end

  // Compare the aligned stage against the RAM data and form the saturating count
  always_comb begin
    mismatch  = pipe_valid[READ_LATENCY-1] &&
                (avm.avm_readdata != pipe_exp[READ_LATENCY-1]);
    err_after = err_count;
    if (mismatch && (err_count != {ERR_W{1'b1}})) begin
      err_after = err_count + ERR_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; an empty window skips straight to completion
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (length == '0) ? S_FIN : S_WRITE;
        end
      end
      S_WRITE: begin
        if (last_word) begin
          state_next = S_READ;
        end
      end
      S_READ: begin
        if (last_word) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!front_busy) begin
          state_next = S_FIN;
        end
      end
      S_FIN: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Capture the run parameters when a start is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q   <= '0;
      length_q <= '0;
      seed_q   <= '0;
    end else if (start_accept) begin
      base_q   <= base;
      length_q <= length;
      seed_q   <= seed;
    end
  end

  // Bus sequencer: one access per cycle, address and data step by one and wrap naturally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_exp_q <= '0;
      cs_q     <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= '0;
      remain_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (length != '0)) begin
            addr_q   <= base;
            wdata_q  <= seed;
            cs_q     <= 1'b1;
            we_q     <= 1'b1;
            be_q     <= '1;
            remain_q <= length - CNT_W'(1);
          end
        end
        S_WRITE: begin
          if (!last_word) begin
            addr_q   <= addr_q + ADDR_W'(1);
            wdata_q  <= wdata_q + DATA_W'(1);
            remain_q <= remain_q - CNT_W'(1);
          end else begin
            addr_q   <= base_q;
            rd_exp_q <= seed_q;
            we_q     <= 1'b0;
            remain_q <= length_q - CNT_W'(1);
          end
        end
        S_READ: begin
          if (!last_word) begin
            addr_q   <= addr_q + ADDR_W'(1);
            rd_exp_q <= rd_exp_q + DATA_W'(1);
            remain_q <= remain_q - CNT_W'(1);
          end else begin
            cs_q <= 1'b0;
            be_q <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Shift read tags behind the registered read strobe so they meet the returning data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_valid[k] <= 1'b0;
        pipe_addr[k]  <= '0;
        pipe_exp[k]   <= '0;
      end
    end else begin
      pipe_valid[0] <= cs_q & ~we_q;
      pipe_addr[0]  <= addr_q;
      pipe_exp[0]   <= rd_exp_q;
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_addr[k]  <= pipe_addr[k-1];
        pipe_exp[k]   <= pipe_exp[k-1];
      end
    end
  end

  // Result tracking; pass settles on the same edge as the final compare
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else if (start_accept) begin
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= (length == '0);
    end else begin
      err_count <= err_after;
      if (mismatch && (err_count == '0)) begin
        first_err_addr <= pipe_addr[READ_LATENCY-1];
      end
      if ((state == S_DRAIN) && (state_next == S_FIN)) begin
        pass <= (err_after == '0);
      end
    end
  end

  assign busy = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
  assign done = (state == S_FIN);

  assign avm.avm_address    = addr_q;
  assign avm.avm_chipselect = cs_q;
  assign avm.avm_write      = we_q;
  assign avm.avm_byteenable = be_q;
  assign avm.avm_writedata  = wdata_q;
  assign avm.avm_clken      = 1'b1;

endmodule

// File: tb/tb_onchip_mem_checker.sv
// Bench for onchip_mem_checker: an ideal synchronous RAM (with optional
// bit0 corruption on readback) sits on the slave side, and a reference
// model derives the expected access list, timing and results directly
// from the window arithmetic.
module tb_onchip_mem_checker;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int EW    = 11;
  localparam int DEPTH = 1 << AW;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           start;
  logic [AW-1:0]  base;
  logic [AW:0]    length;
  logic [DW-1:0]  seed;
  logic           busy;
  logic           done;
  logic           pass;
  logic [EW-1:0]  err_count;
  logic [AW-1:0]  first_err_addr;

  onchip_mem_checker_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  onchip_mem_checker #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .ERR_W(EW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base(base),
    .length(length), .seed(seed), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr),
    .avm(bus_if.master)
  );

  always #5 clk = ~clk;

  // Ideal single-cycle-latency RAM; flagged words come back with bit0 flipped
  logic [DW-1:0] mem [DEPTH];
  bit            corrupt [DEPTH];
  logic [DW-1:0] ram_rdata;
  assign bus_if.avm_readdata = ram_rdata;

  always @(posedge clk) begin
    if (bus_if.avm_chipselect && bus_if.avm_write)
      mem[bus_if.avm_address] <= bus_if.avm_writedata;
    if (bus_if.avm_chipselect && !bus_if.avm_write)
      ram_rdata <= mem[bus_if.avm_address] ^ {{(DW-1){1'b0}}, corrupt[bus_if.avm_address]};
  end

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   k;
  } acc_t;

  acc_t obs_q[$];
  acc_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  int            cur_len, done_cnt, done_k, be_bad, busy_bad;
  logic          pass_at_done;
  logic [EW-1:0] err_at_done;
  logic [AW-1:0] first_at_done;

  int            exp_err, exp_done_k;
  logic [AW-1:0] exp_first;
  logic          exp_pass;

  // Reference: word i lives at (base+i) mod DEPTH and holds seed+i; k counts edges after the start edge
  function automatic void build_model(input logic [AW-1:0] b, input int len, input logic [DW-1:0] s);
    int cnt = 0;
    logic [AW-1:0] a;
    exp_q.delete();
    exp_first = '0;
    for (int i = 0; i < len; i++)
      exp_q.push_back('{1'b1, AW'((int'(b) + i) % DEPTH), s + DW'(i), 32'(i)});
    for (int i = 0; i < len; i++) begin
      a = AW'((int'(b) + i) % DEPTH);
      exp_q.push_back('{1'b0, a, 32'h0, 32'(len + i)});
      if (corrupt[a]) begin
        if (cnt == 0) exp_first = a;
        cnt++;
      end
    end
    exp_err    = (cnt > (1 << EW) - 1) ? (1 << EW) - 1 : cnt;
    exp_pass   = (cnt == 0);
    exp_done_k = (len == 0) ? 0 : 2 * len + 1;
  endfunction

  function automatic int first_diff();
    int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      if (obs_q[i] !== exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic clear_corrupt();
    foreach (corrupt[i]) corrupt[i] = 1'b0;
  endtask

  // Records what the bus and status outputs show k edges after the start edge
  task automatic sample(input int k);
    if (bus_if.avm_chipselect === 1'b1)
      obs_q.push_back('{bus_if.avm_write, bus_if.avm_address,
                        bus_if.avm_write ? bus_if.avm_writedata : 32'h0, 32'(k)});
    if (bus_if.avm_byteenable !== (bus_if.avm_chipselect ? 4'hF : 4'h0)) be_bad++;
    if (busy !== ((cur_len > 0) && (k <= 2 * cur_len))) busy_bad++;
    if (done === 1'b1) begin
      if (done_cnt == 0) begin
        done_k        = k;
        pass_at_done  = pass;
        err_at_done   = err_count;
        first_at_done = first_err_addr;
      end
      done_cnt++;
    end
  endtask

  // Pulses start once, scrambles inputs afterwards, optionally re-pulses start at edge offset restart_k
  task automatic run_once(input logic [AW-1:0] b, input int len, input logic [DW-1:0] s, input int restart_k);
    obs_q.delete();
    done_cnt = 0; done_k = -1; be_bad = 0; busy_bad = 0; cur_len = len;
    pass_at_done = 1'bx; err_at_done = 'x; first_at_done = 'x;
    @(negedge clk); #1;
    start = 1'b1; base = b; length = (AW+1)'(len); seed = s;
    for (int k = 0; k < 2 * len + 12; k++) begin
      @(negedge clk); #1;
      sample(k);
      start  = (k == restart_k);
      base   = AW'($urandom);
      length = (AW+1)'($urandom_range(1, 8));
      seed   = $urandom;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, done, pass, err_count, first_err_addr} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_status: got busy=%b done=%b pass=%b err=%0d first=%h, need all 0",
               busy, done, pass, err_count, first_err_addr);
    end
    n_cmp++;
    if ({bus_if.avm_chipselect, bus_if.avm_write, bus_if.avm_byteenable,
         bus_if.avm_address, bus_if.avm_writedata} !== '0) begin
      n_bad++;
      $display("[TB] FAIL reset_bus: got cs=%b we=%b be=%h addr=%h wd=%h, need all 0",
               bus_if.avm_chipselect, bus_if.avm_write, bus_if.avm_byteenable,
               bus_if.avm_address, bus_if.avm_writedata);
    end
    reset_n = 1'b1;
    @(negedge clk); #1;
    n_cmp++;
    if (bus_if.avm_clken !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_clken: got %b need 1", bus_if.avm_clken);
    end
    n_cmp++;
    if ({busy, done, bus_if.avm_chipselect} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL idle_after_reset: got busy=%b done=%b cs=%b need 0", busy, done, bus_if.avm_chipselect);
    end
  endtask

  task automatic test_basic();
    int fd;
    clear_corrupt();
    build_model(10'h000, 16, 32'hA5A50000);
    run_once(10'h000, 16, 32'hA5A50000, -1);
    fd = first_diff();
    n_cmp++;
    if (fd !== -1) begin n_bad++; $display("[TB] FAIL basic_seq: diff at %0d, got %0d accesses need %0d", fd, obs_q.size(), exp_q.size()); end
    n_cmp++;
    if (done_k !== exp_done_k) begin n_bad++; $display("[TB] FAIL basic_done_time: got %0d need %0d", done_k, exp_done_k); end
    n_cmp++;
    if ({pass_at_done, err_at_done} !== {1'b1, 11'd0}) begin n_bad++; $display("[TB] FAIL basic_result: got pass=%b err=%0d need pass=1 err=0", pass_at_done, err_at_done); end
    n_cmp++;
    if (busy_bad !== 0 || be_bad !== 0) begin n_bad++; $display("[TB] FAIL basic_busy_be: got %0d/%0d bad cycles need 0/0", busy_bad, be_bad); end
  endtask

  task automatic test_wrap();
    int fd;
    logic [DW-1:0] s = $urandom;
    clear_corrupt();
    build_model(10'h3FE, 4, s);
    run_once(10'h3FE, 4, s, -1);
    fd = first_diff();
    n_cmp++;
    if (fd !== -1) begin n_bad++; $display("[TB] FAIL wrap_seq: diff at %0d, got %0d accesses need %0d", fd, obs_q.size(), exp_q.size()); end
    n_cmp++;
    if ({done_k, pass_at_done} !== {exp_done_k, 1'b1}) begin n_bad++; $display("[TB] FAIL wrap_done: got k=%0d pass=%b need k=%0d pass=1", done_k, pass_at_done, exp_done_k); end
  endtask

  task automatic test_corrupt();
    int fd;
    logic [DW-1:0] s = $urandom;
    clear_corrupt();
    corrupt[5] = 1'b1;
    build_model(10'h000, 16, s);
    run_once(10'h000, 16, s, -1);
    fd = first_diff();
    n_cmp++;
    if (fd !== -1) begin n_bad++; $display("[TB] FAIL corrupt_seq: diff at %0d, got %0d accesses need %0d", fd, obs_q.size(), exp_q.size()); end
    n_cmp++;
    if (err_at_done !== 11'd1 || first_at_done !== 10'h005) begin n_bad++; $display("[TB] FAIL corrupt_err: got err=%0d first=%h need err=1 first=005", err_at_done, first_at_done); end
    n_cmp++;
    if (pass_at_done !== 1'b0) begin n_bad++; $display("[TB] FAIL corrupt_pass: got %b need 0", pass_at_done); end
    n_cmp++;
    if (err_count !== 11'd1 || pass !== 1'b0) begin n_bad++; $display("[TB] FAIL corrupt_hold: got err=%0d pass=%b need 1/0", err_count, pass); end
  endtask

  task automatic test_zero_len();
    clear_corrupt();
    build_model(AW'($urandom), 0, $urandom);
    run_once(AW'($urandom), 0, $urandom, -1);
    n_cmp++;
    if (obs_q.size() !== 0) begin n_bad++; $display("[TB] FAIL zero_len_bus: got %0d accesses need 0", obs_q.size()); end
    n_cmp++;
    if (done_k !== 0 || done_cnt !== 1) begin n_bad++; $display("[TB] FAIL zero_len_done: got k=%0d count=%0d need k=0 count=1", done_k, done_cnt); end
    n_cmp++;
    if ({pass_at_done, err_at_done} !== {1'b1, 11'd0}) begin n_bad++; $display("[TB] FAIL zero_len_result: got pass=%b err=%0d need 1/0", pass_at_done, err_at_done); end
    n_cmp++;
    if (busy_bad !== 0) begin n_bad++; $display("[TB] FAIL zero_len_busy: got %0d busy cycles need 0", busy_bad); end
  endtask

  task automatic test_reset_midrun();
    int fd;
    int early_done = 0;
    logic [AW-1:0] b;
    logic [DW-1:0] s;
    clear_corrupt();
    @(negedge clk); #1;
    start = 1'b1; base = AW'($urandom); length = 11'd20; seed = $urandom;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      if (done === 1'b1) early_done++;
    end
    n_cmp++;
    if ({bus_if.avm_chipselect, bus_if.avm_write} !== 2'b11) begin n_bad++; $display("[TB] FAIL midrun_writing: got cs=%b we=%b need 1/1", bus_if.avm_chipselect, bus_if.avm_write); end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, pass, err_count, first_err_addr, bus_if.avm_chipselect, bus_if.avm_write,
         bus_if.avm_byteenable, bus_if.avm_address, bus_if.avm_writedata} !== '0) begin
      n_bad++;
      $display("[TB] FAIL midrun_async_quiet: got busy=%b cs=%b we=%b be=%h addr=%h need all 0",
               busy, bus_if.avm_chipselect, bus_if.avm_write, bus_if.avm_byteenable, bus_if.avm_address);
    end
    repeat (2) begin
      @(negedge clk); #1;
      if (done === 1'b1) early_done++;
    end
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      if (done === 1'b1) early_done++;
    end
    n_cmp++;
    if (early_done !== 0) begin n_bad++; $display("[TB] FAIL midrun_no_done: got %0d done cycles need 0", early_done); end
    b = AW'($urandom);
    s = $urandom;
    build_model(b, 8, s);
    run_once(b, 8, s, -1);
    fd = first_diff();
    n_cmp++;
    if (fd !== -1) begin n_bad++; $display("[TB] FAIL after_reset_seq: diff at %0d, got %0d accesses need %0d", fd, obs_q.size(), exp_q.size()); end
    n_cmp++;
    if ({done_k, pass_at_done} !== {exp_done_k, 1'b1}) begin n_bad++; $display("[TB] FAIL after_reset_done: got k=%0d pass=%b need k=%0d pass=1", done_k, pass_at_done, exp_done_k); end
  endtask

  task automatic test_busy_start();
    int fd;
    logic [AW-1:0] b;
    logic [DW-1:0] s;
    for (int r = 0; r < 2; r++) begin
      clear_corrupt();
      b = AW'($urandom);
      s = $urandom;
      build_model(b, 12, s);
      run_once(b, 12, s, (r == 0) ? 7 : 25);
      fd = first_diff();
      n_cmp++;
      if (fd !== -1) begin n_bad++; $display("[TB] FAIL busy_start_seq%0d: diff at %0d, got %0d accesses need %0d", r, fd, obs_q.size(), exp_q.size()); end
      n_cmp++;
      if (done_cnt !== 1 || done_k !== exp_done_k) begin n_bad++; $display("[TB] FAIL busy_start_done%0d: got count=%0d k=%0d need 1/%0d", r, done_cnt, done_k, exp_done_k); end
    end
  endtask

  task automatic test_random();
    int fd, len, nc;
    logic [AW-1:0] b;
    logic [DW-1:0] s;
    for (int it = 0; it < 8; it++) begin
      clear_corrupt();
      b   = AW'($urandom);
      s   = $urandom;
      len = (it == 7) ? DEPTH : ((it == 3) ? 0 : $urandom_range(1, 48));
      nc  = (len == 0) ? 0 : $urandom_range(0, 3);
      for (int c = 0; c < nc; c++)
        corrupt[AW'((int'(b) + $urandom_range(0, len - 1)) % DEPTH)] = 1'b1;
      build_model(b, len, s);
      run_once(b, len, s, -1);
      fd = first_diff();
      n_cmp++;
      if (fd !== -1) begin n_bad++; $display("[TB] FAIL rand%0d_seq: diff at %0d, got %0d accesses need %0d", it, fd, obs_q.size(), exp_q.size()); end
      n_cmp++;
      if (done_cnt !== 1 || done_k !== exp_done_k) begin n_bad++; $display("[TB] FAIL rand%0d_done: got count=%0d k=%0d need 1/%0d", it, done_cnt, done_k, exp_done_k); end
      n_cmp++;
      if (err_at_done !== EW'(exp_err) || first_at_done !== exp_first || pass_at_done !== exp_pass) begin
        n_bad++;
        $display("[TB] FAIL rand%0d_result: got err=%0d first=%h pass=%b need err=%0d first=%h pass=%b",
                 it, err_at_done, first_at_done, pass_at_done, exp_err, exp_first, exp_pass);
      end
      n_cmp++;
      if (busy_bad !== 0 || be_bad !== 0) begin n_bad++; $display("[TB] FAIL rand%0d_busy_be: got %0d/%0d bad cycles need 0/0", it, busy_bad, be_bad); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    base    = '0;
    length  = '0;
    seed    = '0;
    clear_corrupt();
    test_reset();
    test_basic();
    test_wrap();
    test_corrupt();
    test_zero_len();
    test_reset_midrun();
    test_busy_start();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
